// File: rtl/linebuf_window_ctrl.sv
// ----------------------------------------------------------------------------
// linebuf_window_ctrl
// Walks a FIG_HEIGHT x FIG_WIDTH frame pixel by pixel, feeding a line buffer,
// and flags every position where a complete KERNEL x KERNEL window (stride 1)
// is available. Windows are only released when downstream can take them;
// non-window pixels (the fill region) never stall.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 frame start request (sampled in IDLE only)
//   abort                 synchronous frame cancel
//   pix_valid/pix_ready   upstream pixel handshake
//   lb_in_valid           line-buffer write strobe (= pix_valid & pix_ready)
//   win_ready             downstream can accept a window next cycle
//   win_valid             registered pulse: window available
//   win_row, win_col      top-left coordinate of the flagged window
//   busy                  frame in progress (FILL or RUN)
//   done                  one-cycle frame-complete pulse
// ----------------------------------------------------------------------------
module linebuf_window_ctrl #(
    parameter int unsigned FIG_WIDTH  = 28,
    parameter int unsigned FIG_HEIGHT = 28,
    parameter int unsigned KERNEL     = 3,
    parameter int unsigned COORD_W    = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               pix_valid,
    output logic               pix_ready,
    output logic               lb_in_valid,
    input  logic               win_ready,
    output logic               win_valid,
    output logic [COORD_W-1:0] win_row,
    output logic [COORD_W-1:0] win_col,
    output logic               busy,
    output logic               done
);

    localparam int unsigned COL_W = (FIG_WIDTH  > 1) ? $clog2(FIG_WIDTH)  : 1;
    localparam int unsigned ROW_W = (FIG_HEIGHT > 1) ? $clog2(FIG_HEIGHT) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(FIG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FIG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_K1   = COL_W'(KERNEL - 1);
    localparam logic [ROW_W-1:0] ROW_K1   = ROW_W'(KERNEL - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    logic active;
    logic is_win;
    logic accept;
    logic fill_end;
    logic last_pix;
    logic win_fire;

    // ------------------------------------------------------------------
    // Handshake and position decode
    // ------------------------------------------------------------------
    always_comb begin
        active      = (state == FILL) || (state == RUN);
        is_win      = (row >= ROW_K1) && (col >= COL_K1);
        // Only window positions need downstream room; fill pixels always flow.
        pix_ready   = active && (!is_win || win_ready);
        accept      = pix_valid && pix_ready;
        lb_in_valid = accept;
        fill_end    = (row == ROW_K1) && (col == COL_K1);
        last_pix    = (row == ROW_LAST) && (col == COL_LAST);
        // A window accepted in the abort cycle is dropped.
        win_fire    = accept && is_win && !abort;
        busy        = active;
        done        = (state == DONE);
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (accept && last_pix) begin
                    // Degenerate frame where the first window is also the last pixel.
                    state_nxt = DONE;
                end else if (accept && fill_end) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (accept && last_pix) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Position counters: held at zero outside FILL/RUN, so they are clear
    // on entry to FILL and after abort; advance on accepted pixels only.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (!active || abort) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Window strobe and coordinates (coordinates hold between strobes)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
        end else begin
            win_valid <= win_fire;
            if (win_fire) begin
                win_row <= COORD_W'(row - ROW_K1);
                win_col <= COORD_W'(col - COL_K1);
            end
        end
    end

endmodule
